// File: rtl/fb_pkg.sv
// Frame-buffer shared definitions: writer state encoding, segment tag layout,
// DDR command code and the {frame,y,x} -> af address mapping used by both the
// read and write paths of the frame buffer.
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_CMD   = 3'd4
  } fbw_state_t;

  localparam logic [2:0] AF_CMD_WRITE = 3'b000;
  localparam int         FB_WIDTH     = 800;
  localparam int         SEG_WORDS    = 8;

  // A segment is identified by frame, row and the 8-pixel column block.
  typedef struct packed {
    logic [5:0] frame;
    logic [9:0] y;
    logic [6:0] xblk;
  } seg_tag_t;

  // 8 words x 32 bits = 32 bytes per segment, hence the two zero LSBs
  // address DDR in 8-byte units.
  function automatic logic [30:0] fb_addr(input logic [5:0] frame,
                                          input logic [9:0] y,
                                          input logic [9:0] x);
    return {6'b0, frame, y, x[9:3], 2'b00};
  endfunction

endpackage

// File: rtl/fb_pixel_writer_seg_buffer.sv
// Segment buffer for fb_pixel_writer (module fb_seg_buffer): eight pixel words,
// their valid bits, the segment tag, the incoming-pixel tag compare and the
// beat/mask mux that presents half a segment per DDR beat.
module fb_seg_buffer
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         open,       // start a new segment with this pixel
  input  logic         write,      // write this pixel into the open segment
  input  logic         clear,      // segment retired
  input  logic         beat_sel,   // 0: words 3..0, 1: words 7..4
  input  logic [5:0]   frame_sel,
  input  logic [9:0]   pix_x,
  input  logic [9:0]   pix_y,
  input  logic [31:0]  pix_color,
  output logic         tag_hit,
  output logic         will_fill,  // valid becomes 8'hFF if this pixel is written
  output seg_tag_t     tag,
  output logic [127:0] beat_data,
  output logic [15:0]  beat_mask
);

  seg_tag_t    pix_tag;
  logic [7:0]  sel_bit;
  logic [7:0]  valid;
  logic [31:0] words [SEG_WORDS];

  assign pix_tag   = {frame_sel, pix_y, pix_x[9:3]};
  assign sel_bit   = 8'b1 << pix_x[2:0];
  assign tag_hit   = (pix_tag == tag);
  assign will_fill = ((valid | sel_bit) == 8'hFF);

  // Valid bits and tag: a new segment starts with exactly one valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      valid <= '0;
      tag   <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (open) begin
      valid <= sel_bit;
      tag   <= pix_tag;
    end else if (write) begin
      valid <= valid | sel_bit;
    end
  end

  // Pixel word storage; a rewrite of the same column simply overwrites.
  always_ff @(posedge clk) begin
    // NOTE: the data words are not reset; valid bits alone say which words are
    // meaningful, so resetting the array would only cost reset routing.
    if (open || write) words[pix_x[2:0]] <= pix_color;
  end

  // Beat mux: half a segment per beat, mask bit = 1 for bytes not written.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    beat_data = '0;
    beat_mask = '0;
    for (int i = 0; i < 4; i++) begin
      beat_data[32*i +: 32] = words[{beat_sel, 2'(i)}];
      beat_mask[4*i +: 4]   = {4{~valid[{beat_sel, 2'(i)}]}};
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer pixel writer: coalesces single-pixel writes into 8-pixel
// aligned segments and emits each as a 2-beat masked DDR burst (data beats
// into wdf first, then the write command into af).
// Optional build macro FBW_TIMEOUT_EN: auto-flush a partial segment after
// TIMEOUT_CYCLES cycles in FILL without an accepted pixel.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   frame_sel,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [9:0]   pix_x,
  input  logic [9:0]   pix_y,
  input  logic [31:0]  pix_color,
  input  logic         flush,
  output logic         flush_done,
  output logic         busy,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  input  logic         wdf_full,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
);

`ifdef FBW_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fbw_state_t       state, state_nxt;
  logic             seg_open, seg_write, seg_clear, beat_sel;
  logic             tag_hit, will_fill;
  seg_tag_t         tag;
  logic             flush_pend;
  logic             accept;
  logic             timeout;
  logic [CNT_W-1:0] idle_cnt;

  fb_seg_buffer u_seg (
    .clk       (clk),
    .rst_n     (rst_n),
    .open      (seg_open),
    .write     (seg_write),
    .clear     (seg_clear),
    .beat_sel  (beat_sel),
    .frame_sel (frame_sel),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .tag_hit   (tag_hit),
    .will_fill (will_fill),
    .tag       (tag),
    .beat_data (wdf_din),
    .beat_mask (wdf_mask_din)
  );

  assign accept      = pix_valid && pix_ready;
  assign busy        = (state != ST_IDLE);
  assign af_cmd_din  = AF_CMD_WRITE;
  assign af_addr_din = fb_addr(tag.frame, tag.y, {tag.xblk, 3'b000});
  assign timeout     = TIMEOUT_EN && (state == ST_FILL) && !accept &&
                       (idle_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO/buffer controls; data beats always precede the command.
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    seg_open  = 1'b0;
    seg_write = 1'b0;
    seg_clear = 1'b0;
    beat_sel  = 1'b0;
    wdf_wr_en = 1'b0;
    af_wr_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          seg_open  = 1'b1;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        // A miss is left waiting; it opens the next segment once back in IDLE.
        pix_ready = tag_hit;
        seg_write = pix_valid && tag_hit;
        if (flush || flush_pend || timeout || (seg_write && will_fill) ||
            (pix_valid && !tag_hit))
          state_nxt = ST_BEAT0;
      end
      ST_BEAT0: begin
        wdf_wr_en = !wdf_full;
        if (!wdf_full) state_nxt = ST_BEAT1;
      end
      ST_BEAT1: begin
        beat_sel  = 1'b1;
        wdf_wr_en = !wdf_full;
        if (!wdf_full) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        af_wr_en = !af_full;
        if (!af_full) begin
          seg_clear = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flush bookkeeping: an idle flush retires at once, otherwise it is held
  // until the burst's command is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= (state == ST_IDLE && flush && !pix_valid) ||
                    (af_wr_en && (flush_pend || flush));
      if (af_wr_en)
        flush_pend <= 1'b0;
      else if (flush && !(state == ST_IDLE && !pix_valid))
        flush_pend <= 1'b1;
    end
  end

  // Idle counter for the auto-flush; cleared by any accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           idle_cnt <= '0;
    else if (accept || state != ST_FILL) idle_cnt <= '0;
    else if (idle_cnt != CNT_LAST)        idle_cnt <= idle_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed testbench for fb_pixel_writer.
module tb_fb_pixel_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   frame_sel = '0;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic [9:0]   pix_x = '0;
  logic [9:0]   pix_y = '0;
  logic [31:0]  pix_color = '0;
  logic         flush = 1'b0;
  logic         flush_done;
  logic         busy;
  logic         af_full = 1'b0;
  logic         af_wr_en;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         wdf_full = 1'b0;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int viol = 0;
  int last_acc = 0;

  logic [127:0] wdf_data_q [$];
  logic [15:0]  wdf_mask_q [$];
  int           wdf_cyc_q  [$];
  logic [30:0]  af_addr_q  [$];
  int           af_cyc_q   [$];
  int           fd_cyc_q   [$];

  fb_pixel_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_sel    (frame_sel),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_color    (pix_color),
    .flush        (flush),
    .flush_done   (flush_done),
    .busy         (busy),
    .af_full      (af_full),
    .af_wr_en     (af_wr_en),
    .af_cmd_din   (af_cmd_din),
    .af_addr_din  (af_addr_din),
    .wdf_full     (wdf_full),
    .wdf_wr_en    (wdf_wr_en),
    .wdf_din      (wdf_din),
    .wdf_mask_din (wdf_mask_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every FIFO push and flush_done pulse; inputs are stable here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wdf_wr_en && wdf_full) viol++;
      if (af_wr_en && af_full)   viol++;
      if (wdf_wr_en && !wdf_full) begin
        wdf_data_q.push_back(wdf_din);
        wdf_mask_q.push_back(wdf_mask_din);
        wdf_cyc_q.push_back(cyc);
      end
      if (af_wr_en && !af_full) begin
        if (af_cmd_din !== 3'b000) viol++;
        af_addr_q.push_back(af_addr_din);
        af_cyc_q.push_back(cyc);
      end
      if (flush_done) fd_cyc_q.push_back(cyc);
    end
  end

  task automatic send_pixel(input logic [9:0] x, input logic [9:0] y,
                            input logic [31:0] c);
    bit ok;
    ok = 1'b0;
    pix_valid = 1'b1; pix_x = x; pix_y = y; pix_color = c;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (pix_ready) begin ok = 1'b1; last_acc = cyc; end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL pixel_accept x=%0d y=%0d: got no accept, expected accept within 300 cycles", x, y);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s idle_wait: busy stayed 1, expected 0 within 300 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({pix_ready, af_wr_en, wdf_wr_en, flush_done, busy} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got {rdy,af,wdf,fd,busy}=%b expected 10000",
               {pix_ready, af_wr_en, wdf_wr_en, flush_done, busy});
    end
    vectors++;
    if (af_addr_din !== 31'h0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h expected 0", af_addr_din);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_full_segment();
    int wb, ab, fb;
    wb = wdf_data_q.size(); ab = af_addr_q.size(); fb = fd_cyc_q.size();
    frame_sel = 6'd2;
    for (int x = 16; x < 24; x++) send_pixel(10'(x), 10'd5, 32'hA000_0000 | x);
    frame_sel = 6'd0;
    wait_idle("full");
    vectors++;
    if (wdf_data_q.size() != wb + 2 || af_addr_q.size() != ab + 1) begin
      miscompares++;
      $display("FAIL full_counts: got wdf=%0d af=%0d expected wdf=2 af=1",
               wdf_data_q.size() - wb, af_addr_q.size() - ab);
    end else begin
      vectors++;
      if (wdf_data_q[wb] !== 128'hA0000013_A0000012_A0000011_A0000010 || wdf_mask_q[wb] !== 16'h0000) begin
        miscompares++;
        $display("FAIL full_beat0: got %h/%h expected A0000013A0000012A0000011A0000010/0000",
                 wdf_data_q[wb], wdf_mask_q[wb]);
      end
      vectors++;
      if (wdf_data_q[wb+1] !== 128'hA0000017_A0000016_A0000015_A0000014 || wdf_mask_q[wb+1] !== 16'h0000) begin
        miscompares++;
        $display("FAIL full_beat1: got %h/%h expected A0000017A0000016A0000015A0000014/0000",
                 wdf_data_q[wb+1], wdf_mask_q[wb+1]);
      end
      vectors++;
      if (af_addr_q[ab] !== 31'h0100A08) begin
        miscompares++;
        $display("FAIL full_addr: got %h expected 0100a08", af_addr_q[ab]);
      end
      vectors++;
      if (wdf_cyc_q[wb] != last_acc + 1 || wdf_cyc_q[wb+1] != last_acc + 2 || af_cyc_q[ab] != last_acc + 3) begin
        miscompares++;
        $display("FAIL full_latency: got wdf+%0d,+%0d af+%0d expected +1,+2,+3",
                 wdf_cyc_q[wb] - last_acc, wdf_cyc_q[wb+1] - last_acc, af_cyc_q[ab] - last_acc);
      end
    end
    vectors++;
    if (fd_cyc_q.size() != fb) begin
      miscompares++;
      $display("FAIL full_no_flush_done: got %0d pulses expected 0", fd_cyc_q.size() - fb);
    end
  endtask

  task automatic test_partial_flush();
    int wb, ab, fb;
    wb = wdf_data_q.size(); ab = af_addr_q.size(); fb = fd_cyc_q.size();
    send_pixel(10'd3, 10'd0, 32'hDEAD_BEEF);
    pulse_flush();
    wait_idle("partial");
    vectors++;
    if (wdf_data_q.size() != wb + 2 || af_addr_q.size() != ab + 1 || fd_cyc_q.size() != fb + 1) begin
      miscompares++;
      $display("FAIL partial_counts: got wdf=%0d af=%0d fd=%0d expected 2 1 1",
               wdf_data_q.size() - wb, af_addr_q.size() - ab, fd_cyc_q.size() - fb);
    end else begin
      vectors++;
      if (wdf_mask_q[wb] !== 16'h0FFF || wdf_data_q[wb][127:96] !== 32'hDEAD_BEEF) begin
        miscompares++;
        $display("FAIL partial_beat0: got mask %h word3 %h expected 0fff deadbeef",
                 wdf_mask_q[wb], wdf_data_q[wb][127:96]);
      end
      vectors++;
      if (wdf_mask_q[wb+1] !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL partial_beat1_mask: got %h expected ffff", wdf_mask_q[wb+1]);
      end
      vectors++;
      if (af_addr_q[ab] !== 31'h0) begin
        miscompares++;
        $display("FAIL partial_addr: got %h expected 0", af_addr_q[ab]);
      end
      vectors++;
      if (fd_cyc_q[fb] != af_cyc_q[ab] + 1) begin
        miscompares++;
        $display("FAIL partial_flush_done_time: got af+%0d expected af+1", fd_cyc_q[fb] - af_cyc_q[ab]);
      end
    end
  endtask

  task automatic test_flush_idle();
    int wb, ab;
    wb = wdf_data_q.size(); ab = af_addr_q.size();
    pulse_flush();
    @(negedge clk);
    vectors++;
    if (flush_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_flush_pulse: got fd=%b busy=%b expected 1 0", flush_done, busy);
    end
    @(negedge clk);
    vectors++;
    if (flush_done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_flush_single: got fd=%b expected 0", flush_done);
    end
    vectors++;
    if (wdf_data_q.size() != wb || af_addr_q.size() != ab) begin
      miscompares++;
      $display("FAIL idle_flush_traffic: got wdf=%0d af=%0d expected 0 0",
               wdf_data_q.size() - wb, af_addr_q.size() - ab);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_miss();
    int wb, ab, fb;
    wb = wdf_data_q.size(); ab = af_addr_q.size(); fb = fd_cyc_q.size();
    send_pixel(10'd0, 10'd7, 32'h1111_0000);
    pix_valid = 1'b1; pix_x = 10'd8; pix_y = 10'd7; pix_color = 32'h2222_0008;
    @(negedge clk);
    vectors++;
    if (pix_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_ready: got %b expected 0", pix_ready);
    end
    @(posedge clk); #1;
    send_pixel(10'd8, 10'd7, 32'h2222_0008);
    vectors++;
    if (af_addr_q.size() != ab + 1 || wdf_data_q.size() != wb + 2) begin
      miscompares++;
      $display("FAIL miss_first_burst: got af=%0d wdf=%0d expected 1 2",
               af_addr_q.size() - ab, wdf_data_q.size() - wb);
    end else begin
      vectors++;
      if (af_addr_q[ab] !== 31'h0000E00 || wdf_mask_q[wb] !== 16'hFFF0 ||
          wdf_data_q[wb][31:0] !== 32'h1111_0000) begin
        miscompares++;
        $display("FAIL miss_seg0: got addr %h mask %h w0 %h expected 0000e00 fff0 11110000",
                 af_addr_q[ab], wdf_mask_q[wb], wdf_data_q[wb][31:0]);
      end
      vectors++;
      if (last_acc != af_cyc_q[ab] + 1) begin
        miscompares++;
        $display("FAIL miss_accept_time: got af+%0d expected af+1", last_acc - af_cyc_q[ab]);
      end
    end
    pulse_flush();
    wait_idle("miss");
    vectors++;
    if (af_addr_q.size() != ab + 2 || fd_cyc_q.size() != fb + 1) begin
      miscompares++;
      $display("FAIL miss_second_burst: got af=%0d fd=%0d expected 2 1",
               af_addr_q.size() - ab, fd_cyc_q.size() - fb);
    end else begin
      vectors++;
      if (af_addr_q[ab+1] !== 31'h0000E04 || wdf_mask_q[wb+2] !== 16'hFFF0 ||
          wdf_data_q[wb+2][31:0] !== 32'h2222_0008) begin
        miscompares++;
        $display("FAIL miss_seg1: got addr %h mask %h w0 %h expected 0000e04 fff0 22220008",
                 af_addr_q[ab+1], wdf_mask_q[wb+2], wdf_data_q[wb+2][31:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int wb, ab, fb;
    wb = wdf_data_q.size(); ab = af_addr_q.size(); fb = fd_cyc_q.size();
    viol = 0;
    wdf_full = 1'b1; af_full = 1'b1;
    send_pixel(10'd40, 10'd1, 32'h3333_3333);
    pulse_flush();
    repeat (10) @(posedge clk);
    #1;
    wdf_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (wdf_data_q.size() != wb + 2 || af_addr_q.size() != ab || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_in_cmd: got wdf=%0d af=%0d busy=%b expected 2 0 1",
               wdf_data_q.size() - wb, af_addr_q.size() - ab, busy);
    end
    repeat (5) @(posedge clk);
    #1;
    af_full = 1'b0;
    wait_idle("backpressure");
    vectors++;
    if (wdf_data_q.size() != wb + 2 || af_addr_q.size() != ab + 1 || fd_cyc_q.size() != fb + 1) begin
      miscompares++;
      $display("FAIL bp_counts: got wdf=%0d af=%0d fd=%0d expected 2 1 1",
               wdf_data_q.size() - wb, af_addr_q.size() - ab, fd_cyc_q.size() - fb);
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL bp_enable_while_full: got %0d violations expected 0", viol);
    end
  endtask

  task automatic test_reset_mid_burst();
    int wb, ab;
    send_pixel(10'd100, 10'd2, 32'h4444_4444);
    pulse_flush();
    @(posedge clk); #1;
    wdf_full = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || wdf_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pre: got busy=%b wdf_wr_en=%b expected 1 0", busy, wdf_wr_en);
    end
    wb = wdf_data_q.size(); ab = af_addr_q.size();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pix_ready, af_wr_en, wdf_wr_en, flush_done, busy} !== 5'b10000 || af_addr_din !== 31'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got {rdy,af,wdf,fd,busy}=%b addr=%h expected 10000 0",
               {pix_ready, af_wr_en, wdf_wr_en, flush_done, busy}, af_addr_din);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; wdf_full = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (af_addr_q.size() != ab || wdf_data_q.size() != wb || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_after: got af=%0d wdf=%0d busy=%b expected 0 0 0",
               af_addr_q.size() - ab, wdf_data_q.size() - wb, busy);
    end
  endtask

  task automatic test_timeout();
    int wb, ab, fb;
    wb = wdf_data_q.size(); ab = af_addr_q.size(); fb = fd_cyc_q.size();
    send_pixel(10'd200, 10'd3, 32'h5555_5555);
`ifdef FBW_TIMEOUT_EN
    wait_idle("timeout");
    vectors++;
    if (af_addr_q.size() != ab + 1 || fd_cyc_q.size() != fb) begin
      miscompares++;
      $display("FAIL timeout_burst: got af=%0d fd=%0d expected 1 0",
               af_addr_q.size() - ab, fd_cyc_q.size() - fb);
    end else begin
      vectors++;
      if (af_cyc_q[ab] < last_acc + 64) begin
        miscompares++;
        $display("FAIL timeout_early: got af at acc+%0d expected at least acc+64", af_cyc_q[ab] - last_acc);
      end
    end
`else
    repeat (80) @(posedge clk);
    #1;
    vectors++;
    if (wdf_data_q.size() != wb || af_addr_q.size() != ab || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL no_timeout: got wdf=%0d af=%0d busy=%b expected 0 0 1",
               wdf_data_q.size() - wb, af_addr_q.size() - ab, busy);
    end
    pulse_flush();
    wait_idle("no_timeout_flush");
    vectors++;
    if (af_addr_q.size() != ab + 1 || fd_cyc_q.size() != fb + 1) begin
      miscompares++;
      $display("FAIL no_timeout_flush: got af=%0d fd=%0d expected 1 1",
               af_addr_q.size() - ab, fd_cyc_q.size() - fb);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_segment();
    test_partial_flush();
    test_flush_idle();
    test_miss();
    test_backpressure();
    test_reset_mid_burst();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
